ss_demap_sched: RTL and testbench

- Per-frame scheduler in front of the spread-spectrum demapper in the Rx chain, between FFT output and the demapper.
- Latches the frame configuration (spreading factor, modulation index, symbol count).
- Selects the active subcarrier window of each OFDM symbol and forwards whole spreading groups only, one register stage, to the demapper.
- Forces a one-cycle ival gap between symbols so the demapper accumulator restarts aligned, and reports frame completion and framing errors.

---
 rtl/ss_demap_sched.sv | 148 ++++++++++++++
 tb/tb_ss_demap_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_demap_sched.sv
// ss_demap_sched
// Per-frame scheduler between the FFT output and the spread-spectrum demapper.
// Latches the frame configuration, forwards only whole spreading groups from
// the active subcarrier window of each symbol (one register stage), inserts a
// one-cycle valid gap between symbols and flags frame completion and framing
// errors.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_val/cfg_rdy       configuration handshake (accepted in IDLE only)
//   cfg_ss, cfg_m         spreading factor (0 -> 1), modulation index
//   cfg_nsym              symbols per frame (0 -> 1)
//   fft_val, fft_sop      FFT sample valid, first bin of symbol
//   fft_i, fft_q          FFT sample
//   ival, subc_i, subc_q  registered demapper sample stream
//   index_SS, index_M     latched frame configuration for the demapper
//   busy                  high outside IDLE
//   frame_done            pulse when the last symbol has completed
//   err_sop               pulse when fft_sop arrives inside ACTIVE
module ss_demap_sched #(
    parameter int fft_depth = 12,
    parameter int N_FFT     = 1024,
    parameter int ACT_FIRST = 112,
    parameter int ACT_NUM   = 800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_val,
    input  logic [3:0]                  cfg_ss,
    input  logic [2:0]                  cfg_m,
    input  logic [7:0]                  cfg_nsym,
    output logic                        cfg_rdy,
    input  logic                        fft_val,
    input  logic                        fft_sop,
    input  logic signed [fft_depth-1:0] fft_i,
    input  logic signed [fft_depth-1:0] fft_q,
    output logic                        ival,
    output logic signed [fft_depth-1:0] subc_i,
    output logic signed [fft_depth-1:0] subc_q,
    output logic [3:0]                  index_SS,
    output logic [2:0]                  index_M,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        err_sop
);

    localparam int BW = $clog2(N_FFT);
    localparam logic [BW:0]   ACT_LO   = (BW+1)'(ACT_FIRST);
    localparam logic [BW-1:0] BIN_LAST = BW'(N_FFT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOP, ACTIVE, GAP} state_t;

    state_t        state;
    logic [BW-1:0] bin;
    logic [7:0]    sym;
    logic [7:0]    nsym;
    logic [BW:0]   fwd_num;

    logic [3:0]    ss_eff;
    logic [BW:0]   fwd_calc;
    logic          take;
    logic [BW-1:0] bin_idx;
    logic          in_win;
    logic          last_bin;

    always_comb begin
        ss_eff   = (cfg_ss == 4'd0) ? 4'd1 : cfg_ss;
        // Only whole spreading groups are forwarded; the remainder is dropped.
        fwd_calc = (BW+1)'(ACT_NUM - (ACT_NUM % int'(ss_eff)));
        // A sample is consumed in ACTIVE, or as the sop that starts a symbol.
        take     = fft_val && ((state == WAIT_SOP && fft_sop) || state == ACTIVE);
        // Any sop sample is bin 0, including a restart inside ACTIVE.
        bin_idx  = fft_sop ? '0 : bin;
        in_win   = take && ({1'b0, bin_idx} >= ACT_LO)
                        && ({1'b0, bin_idx} < ACT_LO + fwd_num);
        last_bin = (state == ACTIVE) && fft_val && !fft_sop && (bin == BIN_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin        <= '0;
            sym        <= '0;
            nsym       <= '0;
            fwd_num    <= '0;
            ival       <= 1'b0;
            subc_i     <= '0;
            subc_q     <= '0;
            index_SS   <= '0;
            index_M    <= '0;
            busy       <= 1'b0;
            cfg_rdy    <= 1'b1;
            frame_done <= 1'b0;
            err_sop    <= 1'b0;
        end else begin
            ival       <= in_win;
            subc_i     <= in_win ? fft_i : '0;
            subc_q     <= in_win ? fft_q : '0;
            err_sop    <= (state == ACTIVE) && fft_val && fft_sop;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_val) begin
                        index_SS <= ss_eff;
                        index_M  <= cfg_m;
                        nsym     <= (cfg_nsym == 8'd0) ? 8'd1 : cfg_nsym;
                        fwd_num  <= fwd_calc;
                        sym      <= '0;
                        bin      <= '0;
                        busy     <= 1'b1;
                        cfg_rdy  <= 1'b0;
                        state    <= WAIT_SOP;
                    end
                end
                WAIT_SOP: begin
                    if (fft_val && fft_sop) begin
                        bin   <= BW'(1);
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fft_val) begin
                        if (fft_sop) begin
                            bin <= BW'(1);
                        end else begin
                            // Wraps to 0 on the last bin, ready for the next symbol.
                            bin <= bin + BW'(1);
                            if (last_bin) state <= GAP;
                        end
                    end
                end
                GAP: begin
                    sym <= sym + 8'd1;
                    if (sym + 8'd1 == nsym) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        cfg_rdy    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT_SOP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_demap_sched.sv
// tb_ss_demap_sched
// Directed bench for ss_demap_sched: a table of frame configurations with
// hand-computed forwarding windows, plus hand-written sequences for an early
// sop with a config attempt while busy, and an asynchronous reset mid-symbol.
module tb_ss_demap_sched;

    localparam int FD = 12;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_val;
    logic [3:0]           cfg_ss;
    logic [2:0]           cfg_m;
    logic [7:0]           cfg_nsym;
    logic                 cfg_rdy;
    logic                 fft_val;
    logic                 fft_sop;
    logic signed [FD-1:0] fft_i;
    logic signed [FD-1:0] fft_q;
    logic                 ival;
    logic signed [FD-1:0] subc_i;
    logic signed [FD-1:0] subc_q;
    logic [3:0]           index_SS;
    logic [2:0]           index_M;
    logic                 busy;
    logic                 frame_done;
    logic                 err_sop;
    logic                 win;

    int n_vec = 0;
    int n_err = 0;

    ss_demap_sched #(
        .fft_depth(FD),
        .N_FFT(1024),
        .ACT_FIRST(112),
        .ACT_NUM(800)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_val(cfg_val),
        .cfg_ss(cfg_ss),
        .cfg_m(cfg_m),
        .cfg_nsym(cfg_nsym),
        .cfg_rdy(cfg_rdy),
        .fft_val(fft_val),
        .fft_sop(fft_sop),
        .fft_i(fft_i),
        .fft_q(fft_q),
        .ival(ival),
        .subc_i(subc_i),
        .subc_q(subc_q),
        .index_SS(index_SS),
        .index_M(index_M),
        .busy(busy),
        .frame_done(frame_done),
        .err_sop(err_sop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream must never stall inside the active window.
    assert property (@(posedge clk) disable iff (!rst_n) win |-> fft_val);

    typedef struct {
        logic [3:0] ss;
        logic [2:0] m;
        logic [7:0] nsym;
        int         exp_idx;
        int         exp_cnt;
        int         exp_first;
        int         exp_last;
        int         nsym_eff;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fft_val = 1'b0;
        fft_sop = 1'b0;
        fft_i   = '0;
        fft_q   = '0;
        win     = 1'b0;
    endtask

    // Streams one symbol (1024 bins, bin value = bin number) and collects what
    // the DUT forwards. restart_at >= 0 injects a second sop at that position;
    // cfg_at >= 0 attempts a configuration while the symbol is active.
    task automatic send_symbol(input int restart_at, input int cfg_at,
                               output int cnt, output int first,
                               output int last, output int bad);
        int total;
        int b;
        cnt   = 0;
        first = -1;
        last  = -1;
        bad   = 0;
        total = (restart_at >= 0) ? restart_at + 1024 : 1024;
        for (int k = 0; k < total; k++) begin
            b = (restart_at >= 0 && k >= restart_at) ? k - restart_at : k;
            if (k == restart_at) begin
                cnt   = 0;
                first = -1;
                last  = -1;
            end
            fft_val = 1'b1;
            fft_sop = (b == 0);
            fft_i   = FD'(b);
            fft_q   = FD'(-b);
            win     = (b >= 112 && b < 912);
            if (k == cfg_at) begin
                cfg_val  = 1'b1;
                cfg_ss   = 4'd8;
                cfg_m    = 3'd6;
                cfg_nsym = 8'd9;
            end else begin
                cfg_val = 1'b0;
            end
            step();
            if (ival) begin
                cnt++;
                if (first < 0) first = int'(subc_i);
                last = int'(subc_i);
                if (int'(subc_q) != -int'(subc_i)) bad++;
            end else if (subc_i != '0 || subc_q != '0) begin
                bad++;
            end
            if (k == restart_at)     check("err_sop_pulse", int'(err_sop), 1);
            if (k == restart_at + 1) check("err_sop_clear", int'(err_sop), 0);
            if (k == cfg_at) begin
                check("busy_cfg_index_SS", int'(index_SS), 4);
                check("busy_cfg_rdy", int'(cfg_rdy), 0);
            end
        end
        cfg_val = 1'b0;
        idle_inputs();
    endtask

    task automatic run_frame(input vec_t v, input int restart_at, input int cfg_at,
                             input string tag);
        int cnt, first, last, bad;
        check({tag, "_idle_rdy"}, int'(cfg_rdy), 1);
        check({tag, "_idle_busy"}, int'(busy), 0);
        cfg_val  = 1'b1;
        cfg_ss   = v.ss;
        cfg_m    = v.m;
        cfg_nsym = v.nsym;
        step();
        cfg_val = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_rdy_low"}, int'(cfg_rdy), 0);
        check({tag, "_index_SS"}, int'(index_SS), v.exp_idx);
        check({tag, "_index_M"}, int'(index_M), int'(v.m));
        for (int s = 0; s < v.nsym_eff; s++) begin
            send_symbol((s == 0) ? restart_at : -1, (s == 0) ? cfg_at : -1,
                        cnt, first, last, bad);
            check($sformatf("%s_s%0d_count", tag, s), cnt, v.exp_cnt);
            check($sformatf("%s_s%0d_first", tag, s), first, v.exp_first);
            check($sformatf("%s_s%0d_last", tag, s), last, v.exp_last);
            check($sformatf("%s_s%0d_data", tag, s), bad, 0);
            // Gap cycle: the DUT is in GAP while this idle input is applied.
            step();
            check($sformatf("%s_s%0d_gap_ival", tag, s), int'(ival), 0);
            check($sformatf("%s_s%0d_done", tag, s), int'(frame_done),
                  (s == v.nsym_eff - 1) ? 1 : 0);
            check($sformatf("%s_s%0d_busy", tag, s), int'(busy),
                  (s == v.nsym_eff - 1) ? 0 : 1);
        end
        step();
        check({tag, "_done_clear"}, int'(frame_done), 0);
        check({tag, "_index_SS_hold"}, int'(index_SS), v.exp_idx);
    endtask

    initial begin
        vec_t hv;
        rst_n    = 1'b0;
        cfg_val  = 1'b0;
        cfg_ss   = '0;
        cfg_m    = '0;
        cfg_nsym = '0;
        idle_inputs();

        //            ss     m     nsym   idx cnt  first last nsym_eff
        vecs[0] = '{4'd4,  3'd2, 8'd2,  4,  800, 112, 911, 2};
        vecs[1] = '{4'd3,  3'd5, 8'd1,  3,  798, 112, 909, 1};
        vecs[2] = '{4'd0,  3'd0, 8'd0,  1,  800, 112, 911, 1};
        vecs[3] = '{4'd7,  3'd7, 8'd1,  7,  798, 112, 909, 1};
        vecs[4] = '{4'd15, 3'd1, 8'd1,  15, 795, 112, 906, 1};

        #12;
        check("rst_ival", int'(ival), 0);
        check("rst_subc_i", int'(subc_i), 0);
        check("rst_subc_q", int'(subc_q), 0);
        check("rst_index_SS", int'(index_SS), 0);
        check("rst_index_M", int'(index_M), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err_sop", int'(err_sop), 0);
        check("rst_cfg_rdy", int'(cfg_rdy), 1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], -1, -1, $sformatf("vec%0d", i));
        end

        // Early sop at bin 500 plus a config attempt at bin 200 of symbol 0.
        hv = '{4'd4, 3'd2, 8'd2, 4, 800, 112, 911, 2};
        run_frame(hv, 500, 200, "early_sop");

        // Asynchronous reset in the middle of a symbol.
        cfg_val  = 1'b1;
        cfg_ss   = 4'd4;
        cfg_m    = 3'd3;
        cfg_nsym = 8'd1;
        step();
        cfg_val = 1'b0;
        for (int b = 0; b <= 300; b++) begin
            fft_val = 1'b1;
            fft_sop = (b == 0);
            fft_i   = FD'(b);
            fft_q   = FD'(-b);
            win     = (b >= 112);
            step();
        end
        check("pre_reset_ival", int'(ival), 1);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("async_ival", int'(ival), 0);
        check("async_subc_i", int'(subc_i), 0);
        check("async_index_SS", int'(index_SS), 0);
        check("async_index_M", int'(index_M), 0);
        check("async_busy", int'(busy), 0);
        check("async_cfg_rdy", int'(cfg_rdy), 1);
        #2;
        rst_n = 1'b1;
        step();
        hv = '{4'd5, 3'd3, 8'd1, 5, 800, 112, 911, 1};
        run_frame(hv, -1, -1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
